// File: rtl/hs2p_sink_if.sv
// Two-phase async input plus valid/ready output of hs2p_sink.
// master drives Req/Data/Ready, slave is the sink.
interface hs2p_sink_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             io_In_HS_Req;
    logic             io_In_HS_Ack;
    logic [WIDTH-1:0] io_In_Data;
    logic             io_Out_Valid;
    logic             io_Out_Ready;
    logic [WIDTH-1:0] io_Out_Data;
    logic [CW-1:0]    io_Count;

    modport master (
        output io_In_HS_Req,
        output io_In_Data,
        output io_Out_Ready,
        input  io_In_HS_Ack,
        input  io_Out_Valid,
        input  io_Out_Data,
        input  io_Count
    );

    modport slave (
        input  io_In_HS_Req,
        input  io_In_Data,
        input  io_Out_Ready,
        output io_In_HS_Ack,
        output io_Out_Valid,
        output io_Out_Data,
        output io_Count
    );
endinterface

// File: rtl/hs2p_sink.sv
// Two-phase bundled-data receiver feeding a first-word
// fall-through FIFO with valid/ready output.
module hs2p_sink #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clock,
    input  logic      reset,
    hs2p_sink_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SYNC_STAGES-2:0] sync;
    logic                   req_s;
    logic                   req_seen;
    logic                   ack;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic [WIDTH-1:0]       mem [DEPTH];

    logic pending;
    logic full;
    logic push;
    logic pop;

    // req_seen is the final synchronizer stage: it only follows
    // req_s on the edge the token is written, so acceptance and
    // Ack land on the same edge the request finishes syncing.
    assign req_s   = sync[SYNC_STAGES-2];
    assign pending = req_s != req_seen;
    assign full    = count == CW'(DEPTH);
    assign push    = pending && !full;
    assign pop     = (count != '0) && bus.io_Out_Ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync     <= '0;
            req_seen <= 1'b0;
            ack      <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            sync[0] <= bus.io_In_HS_Req;
            for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                sync[i] <= sync[i-1];
            end
            if (push) begin
                req_seen <= req_s;
                ack      <= ~ack;
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wr_ptr] <= bus.io_In_Data;
        end
    end

    assign bus.io_In_HS_Ack = ack;
    assign bus.io_Out_Valid = count != '0;
    assign bus.io_Out_Data  = mem[rd_ptr];
    assign bus.io_Count     = count;
endmodule

// File: tb/tb_hs2p_sink.sv
// Bench for hs2p_sink: directed per-cycle vector table plus
// random-traffic and reset-with-pending-token sequences.
module tb_hs2p_sink;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    hs2p_sink_if #(.WIDTH(8), .DEPTH(4)) bus ();

    hs2p_sink #(
        .WIDTH(8),
        .DEPTH(4),
        .SYNC_STAGES(2)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [7:0] data;
        logic       ready;
        logic       eack;
        logic       evalid;
        logic [7:0] edata;
        logic [2:0] ecount;
    } vec_t;

    vec_t vec [19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act,
                         input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic send_wait(input logic [7:0] d);
        bus.io_In_Data   = d;
        bus.io_In_HS_Req = ~bus.io_In_HS_Req;
        for (int n = 0; n < 10; n++) begin
            step();
            if (bus.io_In_HS_Ack == bus.io_In_HS_Req) break;
        end
        check("send_ack", int'(bus.io_In_HS_Ack),
              int'(bus.io_In_HS_Req));
    endtask

    initial begin
        logic [7:0] expq [$];
        logic [7:0] head;
        logic       do_pop;
        logic       waiting;
        logic       last_ack;
        int         sent;
        int         recvd;
        int         toggles;
        int         cyc;

        checks = 0;
        errors = 0;

        // Token 0xA5, then four tokens filling the FIFO while
        // stalled, a fifth held off by backpressure, then drain.
        vec[0]  = '{1, 8'hA5, 1, 0, 0, 8'h00, 0};
        vec[1]  = '{1, 8'hA5, 1, 1, 1, 8'hA5, 1};
        vec[2]  = '{1, 8'hA5, 1, 1, 0, 8'h00, 0};
        vec[3]  = '{0, 8'h11, 0, 1, 0, 8'h00, 0};
        vec[4]  = '{0, 8'h11, 0, 0, 1, 8'h11, 1};
        vec[5]  = '{1, 8'h22, 0, 0, 1, 8'h11, 1};
        vec[6]  = '{1, 8'h22, 0, 1, 1, 8'h11, 2};
        vec[7]  = '{0, 8'h33, 0, 1, 1, 8'h11, 2};
        vec[8]  = '{0, 8'h33, 0, 0, 1, 8'h11, 3};
        vec[9]  = '{1, 8'h44, 0, 0, 1, 8'h11, 3};
        vec[10] = '{1, 8'h44, 0, 1, 1, 8'h11, 4};
        vec[11] = '{0, 8'h55, 0, 1, 1, 8'h11, 4};
        vec[12] = '{0, 8'h55, 0, 1, 1, 8'h11, 4};
        vec[13] = '{0, 8'h55, 0, 1, 1, 8'h11, 4};
        vec[14] = '{0, 8'h55, 1, 1, 1, 8'h22, 3};
        vec[15] = '{0, 8'h55, 1, 0, 1, 8'h33, 3};
        vec[16] = '{0, 8'h55, 1, 0, 1, 8'h44, 2};
        vec[17] = '{0, 8'h55, 1, 0, 1, 8'h55, 1};
        vec[18] = '{0, 8'h55, 1, 0, 0, 8'h00, 0};

        rst_n            = 1'b0;
        bus.io_In_HS_Req = 1'b0;
        bus.io_In_Data   = 8'h00;
        bus.io_Out_Ready = 1'b0;
        step();
        step();
        check("rst_ack", int'(bus.io_In_HS_Ack), 0);
        check("rst_valid", int'(bus.io_Out_Valid), 0);
        check("rst_count", int'(bus.io_Count), 0);
        rst_n = 1'b1;
        step();
        check("rel_ack", int'(bus.io_In_HS_Ack), 0);
        check("rel_valid", int'(bus.io_Out_Valid), 0);
        check("rel_count", int'(bus.io_Count), 0);

        for (int i = 0; i < 19; i++) begin
            bus.io_In_HS_Req = vec[i].req;
            bus.io_In_Data   = vec[i].data;
            bus.io_Out_Ready = vec[i].ready;
            step();
            check($sformatf("v%0d_ack", i),
                  int'(bus.io_In_HS_Ack), int'(vec[i].eack));
            check($sformatf("v%0d_valid", i),
                  int'(bus.io_Out_Valid), int'(vec[i].evalid));
            check($sformatf("v%0d_count", i),
                  int'(bus.io_Count), int'(vec[i].ecount));
            if (vec[i].evalid)
                check($sformatf("v%0d_data", i),
                      int'(bus.io_Out_Data), int'(vec[i].edata));
        end

        // Random traffic: sender waits for Ack, consumer stalls.
        sent     = 0;
        recvd    = 0;
        toggles  = 0;
        waiting  = 1'b0;
        last_ack = bus.io_In_HS_Ack;
        cyc      = 0;
        while (recvd < 16 && cyc < 2000) begin
            if (!waiting && sent < 16) begin
                bus.io_In_Data   = 8'($urandom_range(0, 255));
                bus.io_In_HS_Req = ~bus.io_In_HS_Req;
                expq.push_back(bus.io_In_Data);
                waiting = 1'b1;
                sent++;
            end
            bus.io_Out_Ready = 1'($urandom_range(0, 1));
            #1;
            do_pop = bus.io_Out_Valid && bus.io_Out_Ready;
            head   = bus.io_Out_Data;
            step();
            cyc++;
            if (do_pop) begin
                if (expq.size() == 0) begin
                    check("rnd_extra", 1, 0);
                end else begin
                    check($sformatf("rnd_data%0d", recvd),
                          int'(head), int'(expq.pop_front()));
                end
                recvd++;
            end
            if (bus.io_In_HS_Ack != last_ack) begin
                toggles++;
                last_ack = bus.io_In_HS_Ack;
                waiting  = 1'b0;
            end
            check("rnd_count_max",
                  int'(bus.io_Count <= 3'd4), 1);
        end
        check("rnd_recvd", recvd, 16);
        check("rnd_toggles", toggles, 16);

        // Reset with three buffered tokens and one in flight.
        bus.io_Out_Ready = 1'b0;
        send_wait(8'h01);
        send_wait(8'h02);
        send_wait(8'h03);
        check("pre_rst_count", int'(bus.io_Count), 3);
        bus.io_In_Data   = 8'h99;
        bus.io_In_HS_Req = ~bus.io_In_HS_Req;
        step();
        rst_n            = 1'b0;
        bus.io_In_HS_Req = 1'b0;
        step();
        check("mid_rst_count", int'(bus.io_Count), 0);
        check("mid_rst_valid", int'(bus.io_Out_Valid), 0);
        check("mid_rst_ack", int'(bus.io_In_HS_Ack), 0);
        rst_n = 1'b1;
        step();
        check("post_rst_count", int'(bus.io_Count), 0);
        bus.io_Out_Ready = 1'b1;
        bus.io_In_Data   = 8'h3C;
        bus.io_In_HS_Req = 1'b1;
        step();
        check("resume_ack0", int'(bus.io_In_HS_Ack), 0);
        step();
        check("resume_ack1", int'(bus.io_In_HS_Ack), 1);
        check("resume_valid", int'(bus.io_Out_Valid), 1);
        check("resume_data", int'(bus.io_Out_Data), 8'h3C);
        check("resume_count", int'(bus.io_Count), 1);
        step();
        check("resume_drain", int'(bus.io_Count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
